// File: rtl/dmd_fb_scheduler_pkg.sv
// ============================================================================
// Module      : dmd_fb_scheduler_pkg
// Description : Shared geometry constants and arbiter state encoding for the
//               DMD frame-buffer scheduler (scheduler RTL and its bench).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmd_fb_scheduler_pkg;

    // Frame geometry (both dimensions are powers of two)
    localparam int H_PIXELS = 128;
    localparam int V_LINES  = 32;
    localparam int DATA_W   = 8;

    // Derived address fields: RAM address is {row, col}
    localparam int COL_W    = $clog2(H_PIXELS);
    localparam int LINE_W   = $clog2(V_LINES);
    localparam int ADDR_W   = LINE_W + COL_W;

    // RAM arbiter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } fb_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_rd_pipe.sv
// ============================================================================
// Module      : fb_rd_pipe
// Description : One-stage delay of the fetch read strobe and column so that
//               line-buffer writes line up with the single-cycle RAM read
//               latency.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_rd_valid        - a RAM read was issued this cycle
//               i_rd_col          - column of that read
//               i_rd_data         - RAM read data (valid one cycle later)
//               o_lb_we/o_lb_waddr/o_lb_wdata - line-buffer write port
//               o_line_done       - strobe for the last column of a row
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rd_pipe
    import dmd_fb_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_valid,
    input  logic [COL_W-1:0]  i_rd_col,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_lb_we,
    output logic [COL_W-1:0]  o_lb_waddr,
    output logic [DATA_W-1:0] o_lb_wdata,
    output logic              o_line_done
);

    logic             r_we;
    logic [COL_W-1:0] r_col;
    logic             r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_col  <= '0;
            r_last <= 1'b0;
        end else begin
            r_we   <= i_rd_valid;
            r_col  <= i_rd_col;
            r_last <= i_rd_valid && (i_rd_col == COL_W'(H_PIXELS - 1));
        end
    end

    assign o_lb_we     = r_we;
    assign o_lb_waddr  = r_col;
    // Gated so the line-buffer data bus is quiet (and zero in reset) between strobes
    assign o_lb_wdata  = r_we ? i_rd_data : '0;
    assign o_line_done = r_last;

endmodule

`default_nettype wire

// File: rtl/dmd_fb_scheduler.sv
// ============================================================================
// Module      : dmd_fb_scheduler
// Description : Arbitrates a single-port DMD frame-buffer RAM between host
//               pixel writes and row fetches into the scan-out line buffer.
//               Row fetch has priority; a host write waits at most one fetch.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               i_line_req, i_line_idx        - fetch request and row
//               i_host_req/addr/data, o_host_ack - host write handshake
//               o_ram_addr/we/wdata, i_ram_rdata - frame-buffer RAM port
//               o_lb_we/waddr/wdata, o_line_done - line-buffer write port
//               o_overrun                     - dropped fetch request pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmd_fb_scheduler
    import dmd_fb_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_line_req,
    input  logic [LINE_W-1:0] i_line_idx,
    input  logic              i_host_req,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_data,
    output logic              o_host_ack,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_lb_we,
    output logic [COL_W-1:0]  o_lb_waddr,
    output logic [DATA_W-1:0] o_lb_wdata,
    output logic              o_line_done,
    output logic              o_overrun
);

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_col_nxt;
    logic [LINE_W-1:0] r_row;
    logic [LINE_W-1:0] w_row_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic              w_col_last;
    logic              w_in_write;

    assign w_col_last = (r_col == COL_W'(H_PIXELS - 1));
    assign w_in_write = (r_state == ST_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_wdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_wdata   <= w_wdata_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // WRITE lasts exactly one cycle, so a line request arriving during it is
    // the pending request itself: it is latched and taken straight into FETCH
    // on the next edge. A second request can never queue behind it.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_wdata_nxt   = r_wdata;
        w_overrun_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_line_req) begin
                    w_row_nxt   = i_line_idx;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else if (i_host_req) begin
                    w_wdata_nxt = i_host_data;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_line_req) begin
                    w_row_nxt   = i_line_idx;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_overrun_nxt = i_line_req;
                w_col_nxt     = r_col + 1'b1;   // wraps to 0 after the last column
                if (w_col_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // RAM is free during the final read-latency cycle, so a waiting
                // host write is granted directly; this bounds host starvation.
                w_overrun_nxt = i_line_req;
                if (i_host_req) begin
                    w_wdata_nxt = i_host_data;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_host_ack  = w_in_write;
    assign o_ram_we    = w_in_write;
    assign o_ram_addr  = w_in_write ? i_host_addr : {r_row, r_col};
    assign o_ram_wdata = r_wdata;
    assign o_overrun   = r_overrun;

    fb_rd_pipe u_rd_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_valid  (r_state == ST_FETCH),
        .i_rd_col    (r_col),
        .i_rd_data   (i_ram_rdata),
        .o_lb_we     (o_lb_we),
        .o_lb_waddr  (o_lb_waddr),
        .o_lb_wdata  (o_lb_wdata),
        .o_line_done (o_line_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmd_fb_scheduler.sv
// ============================================================================
// Module      : tb_dmd_fb_scheduler
// Description : Self-checking bench for dmd_fb_scheduler. A timestamp-based
//               model tracks when fetches and writes own the RAM and predicts
//               every output each cycle; literal expectations pin latencies
//               and data values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmd_fb_scheduler;
    import dmd_fb_scheduler_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              line_req;
    logic [LINE_W-1:0] line_idx;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              lb_we;
    logic [COL_W-1:0]  lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              line_done;
    logic              overrun;

    dmd_fb_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_line_req  (line_req),
        .i_line_idx  (line_idx),
        .i_host_req  (host_req),
        .i_host_addr (host_addr),
        .i_host_data (host_data),
        .o_host_ack  (host_ack),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_lb_we     (lb_we),
        .o_lb_waddr  (lb_waddr),
        .o_lb_wdata  (lb_wdata),
        .o_line_done (line_done),
        .o_overrun   (overrun)
    );

    // Single-port synchronous RAM, preloaded with mem[a] = a[7:0]
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    bit                ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < DEPTH; a++) ram[a] <= DATA_W'(a);
            ram_init <= 1'b1;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    // Model state: a fetch accepted in cycle q owns the RAM for reads in
    // q+1..q+H and the drain cycle q+H+1; a write scheduled for cycle wr_at.
    logic [DATA_W-1:0] mm [0:DEPTH-1];
    int                cyc   = 0;
    int                q     = -1000;
    int                wr_at = -1000;
    int                ov_at = -1000;
    bit                wsched = 1'b0;
    logic [LINE_W-1:0] frow = '0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;

    int checks = 0;
    int errors = 0;
    int strobes = 0, dones = 0, ovs = 0, acks = 0;
    int t_done = 0, t_ack = 0, t_req = 0, t_h = 0;
    int cap_col = -1;
    logic [DATA_W-1:0] cap_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, fold this cycle's
    // inputs into the model, then return just after the next rising edge.
    task automatic step();
        int c;
        bit busy;
        bit exp_lb;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            chk("rst_host_ack", host_ack, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_lb_we", lb_we, 0);
            chk("rst_lb_wdata", lb_wdata, 0);
            chk("rst_line_done", line_done, 0);
            chk("rst_overrun", overrun, 0);
            q = -1000; wr_at = -1000; ov_at = -1000; wsched = 1'b0;
        end else begin
            chk("host_ack", host_ack, cyc == wr_at);
            chk("ram_we", ram_we, cyc == wr_at);
            if (cyc == wr_at) begin
                chk("wr_addr", ram_addr, wa);
                chk("wr_data", ram_wdata, wd);
                mm[wa] = wd;
            end
            if (cyc >= q + 1 && cyc <= q + H_PIXELS) begin
                c = cyc - q - 1;
                chk("rd_addr", ram_addr, {frow, COL_W'(c)});
            end
            exp_lb = (cyc >= q + 2 && cyc <= q + H_PIXELS + 1);
            chk("lb_we", lb_we, exp_lb);
            if (exp_lb) begin
                c = cyc - q - 2;
                chk("lb_waddr", lb_waddr, c);
                chk("lb_wdata", lb_wdata, mm[{frow, COL_W'(c)}]);
            end
            chk("line_done", line_done, cyc == q + H_PIXELS + 1);
            chk("overrun", overrun, cyc == ov_at);

            busy = (cyc >= q + 1 && cyc <= q + H_PIXELS + 1);
            if (line_req) begin
                if (busy) ov_at = cyc + 1;
                else begin q = cyc; frow = line_idx; end
            end
            if (wsched && cyc > wr_at) wsched = 1'b0;
            if (host_req && !wsched && !(cyc >= q && cyc <= q + H_PIXELS)) begin
                wr_at = cyc + 1; wsched = 1'b1; wa = host_addr; wd = host_data;
            end
        end
        // DUT-observed tallies for the literal checks
        if (lb_we) strobes++;
        if (lb_we && int'(lb_waddr) == cap_col) cap_val = lb_wdata;
        if (line_done) begin dones++; t_done = cyc; end
        if (overrun) ovs++;
        if (host_ack) begin acks++; t_ack = cyc; end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int a0;
        a0 = acks;
        for (int n = 0; n < 300 && acks == a0; n++) step();
        if (acks == a0) chk("ack_timeout", 0, 1);
        host_req = 1'b0;
    endtask

    task automatic fetch_row(input logic [LINE_W-1:0] row);
        line_req = 1'b1; line_idx = row;
        step();
        t_req = cyc;
        line_req = 1'b0;
        repeat (H_PIXELS + 7) step();
    endtask

    initial begin
        int s0, d0, o0;
        rst_n = 1'b0; line_req = 1'b0; line_idx = '0;
        host_req = 1'b0; host_addr = '0; host_data = '0;
        for (int a = 0; a < DEPTH; a++) mm[a] = DATA_W'(a);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // 1: plain fetch of row 5; byte at {5,col} is 0x80+col
        s0 = strobes; d0 = dones; cap_col = 5;
        fetch_row(5'd5);
        chk("t1_strobes", strobes - s0, 128);
        chk("t1_dones", dones - d0, 1);
        chk("t1_done_latency", t_done - t_req, 129);
        chk("t1_col5_data", cap_val, 8'h85);

        // 2: host write in IDLE, then read it back through a fetch
        host_req = 1'b1; host_addr = 12'h283; host_data = 8'h5A;
        step(); t_h = cyc;
        wait_ack();
        chk("t2_ack_latency", t_ack - t_h, 1);
        step();
        cap_col = 3;
        fetch_row(5'd5);
        chk("t2_readback", cap_val, 8'h5A);

        // 3: simultaneous line_req and host_req - fetch first
        line_req = 1'b1; line_idx = 5'd1;
        host_req = 1'b1; host_addr = 12'h08A; host_data = 8'hC3;
        step(); t_req = cyc; line_req = 1'b0;
        wait_ack();
        chk("t3_ack_after_drain", t_ack - t_req, 130);
        repeat (3) step();

        // 4: line_req during WRITE is serviced with no overrun
        o0 = ovs;
        host_req = 1'b1; host_addr = 12'h7FF; host_data = 8'h11;
        step();
        line_req = 1'b1; line_idx = 5'd7;
        step(); t_req = cyc;
        line_req = 1'b0; host_req = 1'b0;
        chk("t4_ack_in_write", t_ack, t_req);
        repeat (H_PIXELS + 7) step();
        chk("t4_no_overrun", ovs - o0, 0);
        chk("t4_done_latency", t_done - t_req, 129);

        // 5: line_req at column 60 of a fetch is dropped
        s0 = strobes; d0 = dones; o0 = ovs;
        line_req = 1'b1; line_idx = 5'd9;
        step(); t_req = cyc; line_req = 1'b0;
        repeat (60) step();
        line_req = 1'b1; line_idx = 5'd3;
        step(); line_req = 1'b0;
        repeat (H_PIXELS + 7 - 61) step();
        chk("t5_overrun_pulses", ovs - o0, 1);
        chk("t5_strobes", strobes - s0, 128);
        chk("t5_dones", dones - d0, 1);

        // 6: asynchronous reset at column 40 abandons the fetch
        line_req = 1'b1; line_idx = 5'd2;
        step(); line_req = 1'b0;
        repeat (40) step();
        d0 = dones;
        rst_n = 1'b0;
        #1;
        chk("t6_async_lb_we", lb_we, 0);
        chk("t6_async_ram_addr", ram_addr, 0);
        chk("t6_async_ram_wdata", ram_wdata, 0);
        chk("t6_async_line_done", line_done, 0);
        chk("t6_async_host_ack", host_ack, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t6_no_done_after_abort", dones - d0, 0);
        s0 = strobes; d0 = dones; cap_col = 127;
        fetch_row(5'd4);
        chk("t6_strobes", strobes - s0, 128);
        chk("t6_dones", dones - d0, 1);
        chk("t6_last_col_data", cap_val, 8'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
